gate_equiv_sequencer: RTL
=========================

# gate_equiv_sequencer

Clocked sequencer for the gate-experiment bank. It drives the shared `a`/`b` stimulus through all four input combinations, waits a settle interval, and samples two observed gate outputs at each vector. At the end of the sweep it publishes both captured truth tables and equivalence flags, so De Morgan and universal-gate equivalences are checked in hardware rather than by testbench `$monitor` printouts. It sits between a host/bench issuing `start` and the combinational gate modules it stimulates.

## Interface
- `SETTLE`, default 2: cycles from applying a vector to sampling it; legal range 1..15.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a sweep; sampled only in IDLE or DONE.
- `abort`  in  1  synchronous; cancels a sweep in progress.
- `exp_tt`  in  4  expected truth table, latched at start; bit index = {a,b}.
- `obs_x`  in  1  first gate output under test.
- `obs_y`  in  1  second gate output under test.
- `a`  out  1  stimulus A.
- `b`  out  1  stimulus B.
- `busy`  out  1  sweep in progress.
- `done`  out  1  one-cycle pulse; results valid.
- `tt_x`  out  4  published truth table of `obs_x`.
- `tt_y`  out  4  published truth table of `obs_y`.
- `xy_equal`  out  1  `tt_x == tt_y`.
- `x_match_exp`  out  1  `tt_x == exp_tt` as latched.

## Operation
- Reset values: state IDLE; `a`=`b`=0; `busy`=`done`=0; `tt_x`=`tt_y`=0; `xy_equal`=`x_match_exp`=0.
- States:
  - **IDLE**: wait for `start`.
  - **RUN**: vector sweep.
  - **DONE**: one cycle; `done`=1, `busy`=0.
- IDLE/DONE with `start`=1 → RUN:
  - `idx`=0, {`a`,`b`}=00.
  - Settle counter loaded with SETTLE-1.
  - `exp_tt` latched; working tables cleared.
- RUN, counter ≠ 0: decrement.
- RUN, counter = 0: sample the current vector.
  - `obs_x`→`wx[idx]`, `obs_y`→`wy[idx]`.
  - If `idx`<3: `idx`++, {`a`,`b`}=`idx`+1, reload counter.
  - If `idx`=3: publish `tt_x`/`tt_y`/flags from working registers plus the current sample; {`a`,`b`}=00; → DONE.
- `abort` in RUN (priority over sampling): → IDLE, {`a`,`b`}=00, no `done`, published outputs unchanged.
- `start` in RUN is ignored. `abort` outside RUN is ignored.
- Published outputs change only on the transition into DONE and hold until the next completed sweep.
- Reset asserted mid-sweep: all outputs return immediately to reset values.

## Timing
- Edge 0 = the edge where `start` is sampled.
- Vector k (k=0..3) is driven from edge k·SETTLE and sampled at edge (k+1)·SETTLE.
- `busy` is high from edge 0 to edge 4·SETTLE.
- `done` is high for the single cycle after edge 4·SETTLE. Example: SETTLE=2 gives `done` after edge 8.
- A back-to-back `start` during DONE is accepted. `busy` rises at the next edge, with no idle gap.
- `obs_x`/`obs_y` must be stable SETTLE cycles after a vector change. The block does no synchronisation of them.

## Structure
- Package `gate_eq_pkg`:
  - state enum {IDLE, RUN, DONE};
  - `NUM_VECTORS`=4;
  - `SETTLE_W`=4.
- Sub-module `settle_timer`: loadable down-counter with a `zero` flag. The FSM, vector index, working/published tables and comparators live in the top module.

## Test plan
- NAND vs negative-OR, `exp_tt`=4'b0111, SETTLE=2 → `tt_x`=`tt_y`=4'b0111, `xy_equal`=1, `x_match_exp`=1, `done` after edge 8.
- NOR vs negative-AND, `exp_tt`=4'b0001 → both tables 4'b0001, both flags 1; {`a`,`b`} sequence 00,01,10,11 then 00.
- `obs_x`=NAND, `obs_y`=a&b, `exp_tt`=4'b0111 → `tt_y`=4'b1000, `xy_equal`=0, `x_match_exp`=1.
- `abort` during vector 2 after a prior good sweep → no `done`, {`a`,`b`}=00 next cycle, prior published values retained; `start` pulsed again during the sweep is ignored.
- `rst_n` low mid-sweep → `busy`/`done`/`a`/`b`/tables all 0 immediately; a fresh `start` after release sweeps normally.
- SETTLE=1, `start` held high → sweeps repeat back-to-back, `done` every 5 cycles, correct tables each time.

Source files
------------

// File: rtl/gate_equiv_sequencer_pkg.sv
// Shared types and sizing for the gate-equivalence sequencer.
// Provides the FSM state enum, the vector count and the settle-counter width.
package gate_eq_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NUM_VECTORS = 4;
  localparam int SETTLE_W    = 4;
endpackage

// File: rtl/gate_equiv_sequencer_settle_timer.sv
// Loadable down-counter that paces the settle interval between stimulus vectors.
// A load wins over a decrement. The count stops at zero.
module settle_timer
  import gate_eq_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [SETTLE_W-1:0] load_val,
  input  logic                dec,
  output logic                zero
);

  logic [SETTLE_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/gate_equiv_sequencer.sv
// Sweeps a/b through all four input combinations and samples two gate outputs at each one.
// Publishes both truth tables and the equivalence flags once per completed sweep.
module gate_equiv_sequencer
  import gate_eq_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] exp_tt,
  input  logic       obs_x,
  input  logic       obs_y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic [3:0] tt_x,
  output logic [3:0] tt_y,
  output logic       xy_equal,
  output logic       x_match_exp
);

  localparam logic [SETTLE_W-1:0] SETTLE_M1 = SETTLE_W'(SETTLE - 1);
  localparam logic [1:0]          LAST_IDX  = 2'(NUM_VECTORS - 1);

  state_t     state_q;
  logic [1:0] idx_q;
  logic [3:0] wx_q, wy_q, exp_q;
  logic [3:0] wx_n, wy_n;
  logic       tmr_load, tmr_zero, accept, sample;

  assign accept   = (state_q != RUN) && start;
  assign sample   = (state_q == RUN) && !abort && tmr_zero;
  assign tmr_load = accept || (sample && (idx_q != LAST_IDX));

  settle_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (SETTLE_M1),
    .dec      (state_q == RUN),
    .zero     (tmr_zero)
  );

  // Working tables including the sample taken this cycle, so the last vector publishes directly
  always_comb begin
    wx_n        = wx_q;
    wy_n        = wy_q;
    wx_n[idx_q] = obs_x;
    wy_n[idx_q] = obs_y;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= 2'd0;
      a           <= 1'b0;
      b           <= 1'b0;
      wx_q        <= 4'd0;
      wy_q        <= 4'd0;
      exp_q       <= 4'd0;
      tt_x        <= 4'd0;
      tt_y        <= 4'd0;
      xy_equal    <= 1'b0;
      x_match_exp <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= RUN;
            idx_q   <= 2'd0;
            {a, b}  <= 2'b00;
            exp_q   <= exp_tt;
            wx_q    <= 4'd0;
            wy_q    <= 4'd0;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          if (abort) begin
            state_q <= IDLE;
            {a, b}  <= 2'b00;
          end else if (tmr_zero) begin
            wx_q <= wx_n;
            wy_q <= wy_n;
            if (idx_q != LAST_IDX) begin
              idx_q  <= idx_q + 2'd1;
              {a, b} <= idx_q + 2'd1;
            end else begin
              tt_x        <= wx_n;
              tt_y        <= wy_n;
              xy_equal    <= (wx_n == wy_n);
              x_match_exp <= (wx_n == exp_q);
              {a, b}      <= 2'b00;
              state_q     <= DONE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule
